// File: rtl/conv_input_interface.sv
// Conv layer input responder: fetches image rows into a line buffer
// and serves kernel-tap windows to the PE array on command.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   enable                low aborts to IDLE at the next edge
//   input_interface_cmd   0 idle, 1 load row, 2 shift tap, 3 reserved
//   img_base              frame base, sampled on the frame's first LOAD
//   mem_rd_en/mem_addr    memory read port (1-cycle read latency)
//   mem_rdata             read data, one cycle after mem_rd_en
//   input_interface_ack   1 load done, 2 shift done (one-cycle pulse)
//   array_data            tap window, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy                  high while a LOAD is in flight
module conv_input_interface #(
  parameter int KERNEL_SIZE  = 2,
  parameter int ARRAY_SIZE   = 6,
  parameter int IMAGE_SIZE   = 7,
  parameter int TOTAL_WEIGHT = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [1:0]                       input_interface_cmd,
  input  logic [ADDR_WIDTH-1:0]            img_base,
  input  logic [DATA_WIDTH-1:0]            mem_rdata,
  output logic [1:0]                       input_interface_ack,
  output logic                             mem_rd_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] array_data,
  output logic                             busy
);

  localparam logic [1:0] CMD_LOAD      = 2'd1;
  localparam logic [1:0] CMD_SHIFT     = 2'd2;
  localparam logic [1:0] ACK_IDLE      = 2'd0;
  localparam logic [1:0] ACK_LOAD_FIN  = 2'd1;
  localparam logic [1:0] ACK_SHIFT_FIN = 2'd2;

  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] TAP_LAST = CNT_WIDTH'(TOTAL_WEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] KSZ      = CNT_WIDTH'(KERNEL_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_ACK
  } state_t;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]  row_ptr_q, row_ptr_d;
  logic [CNT_WIDTH-1:0]  col_cnt_q, col_cnt_d;
  logic [CNT_WIDTH-1:0]  tap_idx_q, tap_idx_d;
  logic [CNT_WIDTH-1:0]  cap_col_q, cap_col_d;
  logic                  cap_vld_q, cap_vld_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            ack_q, ack_d;

  logic [DATA_WIDTH-1:0] stg_q [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] stg_d [IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] line_q [KERNEL_SIZE][IMAGE_SIZE];
  logic [DATA_WIDTH-1:0] line_d [KERNEL_SIZE][IMAGE_SIZE];

  logic [ARRAY_SIZE*DATA_WIDTH-1:0] win_q, win_d;

  logic [CNT_WIDTH-1:0]  tap_row;
  logic [CNT_WIDTH-1:0]  tap_col;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign tap_row = tap_idx_q / KSZ;
  assign tap_col = tap_idx_q % KSZ;

  assign rd_addr = base_q
                 + ADDR_WIDTH'(row_ptr_q) * ADDR_WIDTH'(IMAGE_SIZE)
                 + ADDR_WIDTH'(col_cnt_q);

  assign mem_rd_en           = (state_q == S_READ);
  assign mem_addr            = mem_rd_en ? rd_addr : '0;
  assign busy                = (state_q != S_IDLE);
  assign input_interface_ack = ack_q;
  assign array_data          = win_q;

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    col_cnt_d = col_cnt_q;
    tap_idx_d = tap_idx_q;
    cap_col_d = col_cnt_q;
    cap_vld_d = 1'b0;
    base_d    = base_q;
    ack_d     = ACK_IDLE;
    stg_d     = stg_q;
    line_d    = line_q;
    win_d     = win_q;

    // Read data trails its address by one cycle.
    for (int c = 0; c < IMAGE_SIZE; c++) begin
      if (enable && cap_vld_q && cap_col_q == CNT_WIDTH'(c)) begin
        stg_d[c] = mem_rdata;
      end
    end

    if (!enable) begin
      state_d   = S_IDLE;
      row_ptr_d = '0;
      col_cnt_d = '0;
      tap_idx_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            (input_interface_cmd == CMD_LOAD): begin
              state_d   = S_READ;
              col_cnt_d = '0;
              if (row_ptr_q == '0) begin
                base_d = img_base;
              end
            end
            (input_interface_cmd == CMD_SHIFT): begin
              for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int j = 0; j < KERNEL_SIZE; j++) begin
                  if (tap_row == CNT_WIDTH'(r) &&
                      tap_col == CNT_WIDTH'(j)) begin
                    for (int k = 0; k < ARRAY_SIZE; k++) begin
                      win_d[k*DATA_WIDTH +: DATA_WIDTH] = line_q[r][j+k];
                    end
                  end
                end
              end
              ack_d     = ACK_SHIFT_FIN;
              tap_idx_d = (tap_idx_q == TAP_LAST) ? '0 : tap_idx_q + 1'b1;
            end
            default: ;
          endcase
        end
        S_READ: begin
          cap_vld_d = 1'b1;
          col_cnt_d = col_cnt_q + 1'b1;
          if (col_cnt_q == COL_LAST) begin
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Ack is registered, so raise it here to land in the ACK cycle.
          state_d = S_ACK;
          ack_d   = ACK_LOAD_FIN;
        end
        S_ACK: begin
          for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
            line_d[r] = line_q[r+1];
          end
          line_d[KERNEL_SIZE-1] = stg_q;
          tap_idx_d = '0;
          row_ptr_d = (row_ptr_q == ROW_LAST) ? '0 : row_ptr_q + 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_ptr_q <= '0;
      col_cnt_q <= '0;
      tap_idx_q <= '0;
      cap_col_q <= '0;
      cap_vld_q <= 1'b0;
      base_q    <= '0;
      ack_q     <= ACK_IDLE;
      win_q     <= '0;
      for (int c = 0; c < IMAGE_SIZE; c++) begin
        stg_q[c] <= '0;
      end
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < IMAGE_SIZE; c++) begin
          line_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      col_cnt_q <= col_cnt_d;
      tap_idx_q <= tap_idx_d;
      cap_col_q <= cap_col_d;
      cap_vld_q <= cap_vld_d;
      base_q    <= base_d;
      ack_q     <= ack_d;
      win_q     <= win_d;
      stg_q     <= stg_d;
      line_q    <= line_d;
    end
  end

endmodule

// File: tb/tb_conv_input_interface.sv
// Bench for conv_input_interface: directed command sequences checked
// against a cycle-indexed behavioural model plus literal expectations.
module tb_conv_input_interface;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int AS = 6;
  localparam int NC = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b1;
  logic [1:0]        cmd = 2'd0;
  logic [AW-1:0]     img_base = '0;
  logic [DW-1:0]     mem_rdata;
  logic [1:0]        ack;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [AS*DW-1:0]  array_data;
  logic              busy;

  conv_input_interface dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (enable),
    .input_interface_cmd (cmd),
    .img_base            (img_base),
    .mem_rdata           (mem_rdata),
    .input_interface_ack (ack),
    .mem_rd_en           (mem_rd_en),
    .mem_addr            (mem_addr),
    .array_data          (array_data),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  // Memory: each word holds its own address, one cycle of read latency.
  logic [AW-1:0] rd_addr_q = '0;
  always @(posedge clk) rd_addr_q <= mem_addr;
  assign mem_rdata = DW'(rd_addr_q);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [191:0] act,
                     input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: bound expired", nm, cyc);
  endtask

  // Behavioural model: expected outputs indexed by cycle number.
  logic [1:0]   e_ack  [NC];
  bit           e_rd   [NC];
  logic [7:0]   e_addr [NC];
  bit           e_busy [NC];
  bit           a_upd  [NC];
  logic [191:0] a_val  [NC];
  logic [31:0]  m_buf  [2][7];
  logic [31:0]  pend_row [7];
  int           commit_cyc = -1;
  int           m_row = 0;
  int           m_tap = 0;
  logic [7:0]   m_base = '0;
  logic [191:0] cur_arr = '0;
  bit           chk_en = 1'b0;

  task automatic model_clear(input int from);
    for (int t = from; t < NC; t++) begin
      e_ack[t]  = 2'd0;
      e_rd[t]   = 1'b0;
      e_addr[t] = 8'd0;
      e_busy[t] = 1'b0;
      a_upd[t]  = 1'b0;
      a_val[t]  = '0;
    end
  endtask

  task automatic model_reset(input int from);
    model_clear(from);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 7; c++) m_buf[r][c] = '0;
    commit_cyc = -1;
    m_row = 0;
    m_tap = 0;
    cur_arr = '0;
  endtask

  task automatic model_abort(input int n);
    model_clear(n + 1);
    commit_cyc = -1;
    m_row = 0;
    m_tap = 0;
  endtask

  // Command held during cycle n; the block is free iff it is idle in n.
  task automatic model_cmd(input int n, input logic [1:0] c);
    logic [7:0]   a;
    logic [191:0] v;
    if (!enable || e_busy[n] || n + 10 >= NC) return;
    if (c == 2'd1) begin
      if (m_row == 0) m_base = img_base;
      for (int k = 0; k < 7; k++) begin
        a = m_base + 8'(m_row * 7 + k);
        e_rd[n+1+k]   = 1'b1;
        e_addr[n+1+k] = a;
        pend_row[k]   = 32'(a);
      end
      for (int t = n + 1; t <= n + 9; t++) e_busy[t] = 1'b1;
      e_ack[n+9] = 2'd1;
      commit_cyc = n + 9;
    end else if (c == 2'd2) begin
      v = '0;
      for (int k = 0; k < AS; k++)
        v[k*DW +: DW] = m_buf[m_tap / 2][m_tap % 2 + k];
      a_upd[n+1] = 1'b1;
      a_val[n+1] = v;
      e_ack[n+1] = 2'd2;
      m_tap = (m_tap + 1) % 4;
    end
  endtask

  // Single compare process, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n && cyc < NC) begin
        if (cyc == commit_cyc) begin
          for (int c = 0; c < 7; c++) begin
            m_buf[0][c] = m_buf[1][c];
            m_buf[1][c] = pend_row[c];
          end
          m_row = (m_row + 1) % 7;
          m_tap = 0;
        end
        if (a_upd[cyc]) cur_arr = a_val[cyc];
        chk("ack", ack, e_ack[cyc]);
        chk("mem_rd_en", mem_rd_en, e_rd[cyc]);
        chk("busy", busy, e_busy[cyc]);
        if (e_rd[cyc]) chk("mem_addr", mem_addr, e_addr[cyc]);
        chk("array_data", array_data, cur_arr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c);
    cmd = c;
    model_cmd(cyc, c);
    tick();
    cmd = 2'd0;
  endtask

  task automatic wait_load(input int n, input bit chk_first,
                           input logic [7:0] first_exp);
    bit seen = 1'b0;
    bit got = 1'b0;
    for (int i = 0; i < 14 && !got; i++) begin
      if (mem_rd_en && !seen) begin
        seen = 1'b1;
        if (chk_first) chk("first_addr", mem_addr, first_exp);
      end
      if (ack == 2'd1) begin
        got = 1'b1;
        chk("load_latency", cyc - n, 9);
      end else begin
        tick();
      end
    end
    if (!got) fail_now("load_ack");
    tick();
  endtask

  task automatic do_load(input logic [7:0] base, input bit chk_first,
                         input logic [7:0] first_exp);
    int n;
    img_base = base;
    n = cyc;
    issue(2'd1);
    wait_load(n, chk_first, first_exp);
  endtask

  task automatic do_shift(input bit lit, input logic [31:0] start);
    logic [191:0] v;
    issue(2'd2);
    if (lit) begin
      for (int k = 0; k < AS; k++) v[k*DW +: DW] = start + 32'(k);
      chk("shift_window", array_data, v);
      chk("shift_ack", ack, 2'd2);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    model_reset(0);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ack", ack, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_array", array_data, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset while reading column 3.
    img_base = 8'h40;
    issue(2'd1);
    tick();
    tick();
    tick();
    chk("mid_read_col3_addr", mem_addr, 8'h43);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd_en", mem_rd_en, 0);
    chk("async_rst_addr", mem_addr, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ack", ack, 0);
    model_reset(cyc);
    tick();
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Two preloads, then one full tap sweep and a wrap.
    do_load(8'h10, 1'b1, 8'h10);
    do_load(8'h55, 1'b1, 8'h17);
    do_shift(1'b1, 32'h10);
    do_shift(1'b1, 32'h11);
    do_shift(1'b1, 32'h17);
    do_shift(1'b1, 32'h18);
    do_shift(1'b1, 32'h10);

    // Rest of the frame; base is not resampled mid-frame.
    for (int r = 2; r < 7; r++) begin
      do_load(8'h99, r == 6, 8'h3A);
      for (int s = 0; s < 4; s++) do_shift(1'b0, 32'h0);
    end
    do_load(8'h80, 1'b1, 8'h80);
    do_shift(1'b0, 32'h0);

    // Commands during READ are dropped.
    n = cyc;
    issue(2'd1);
    tick();
    issue(2'd2);
    issue(2'd1);
    wait_load(n, 1'b0, 8'h0);

    // Abort at column 4.
    issue(2'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_col4_addr", mem_addr, 8'h80 + 8'd14 + 8'd4);
    enable = 1'b0;
    model_abort(cyc);
    tick();
    enable = 1'b1;
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 10; i++) tick();
    do_load(8'hA0, 1'b1, 8'hA0);
    do_shift(1'b0, 32'h0);
    do_shift(1'b0, 32'h0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
